// File: rtl/chip_host_driver.sv
// Host-side sequencer for a chip with ui/uio/uo ports: it drives the operands,
// polls the done bit uio[7] and returns the captured outputs, or a timeout.
module chip_host_driver #(
  parameter int SETTLE   = 1,
  parameter int WAIT_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_uo,
  output logic [7:0] rsp_uio,
  output logic       rsp_timeout,
  output logic       busy,
  output logic       dut_ena,
  output logic [7:0] dut_ui_in,
  output logic [7:0] dut_uio_in,
  input  logic [7:0] dut_uo_out,
  input  logic [7:0] dut_uio_out,
  input  logic [7:0] dut_uio_oe
);

  // state   | meaning
  // S_IDLE  | ready for a command, chip disabled
  // S_DRIVE | operands on the chip pins, waiting SETTLE cycles
  // S_WAIT  | polling done (uio[7]) up to WAIT_MAX cycles
  // S_RESP  | captured response presented until consumed
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [7:0] WAIT_LAST   = 8'(WAIT_MAX - 1);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [7:0] r_uo;
  logic [7:0] r_uio;
  logic       r_timeout;

  logic       w_done;
  logic       w_settle_end;
  logic       w_wait_end;

  assign w_done       = dut_uio_oe[7] & dut_uio_out[7];
  assign w_settle_end = (r_state == S_DRIVE) && (r_cnt == SETTLE_LAST);
  // done wins over the timeout compare in the last poll cycle
  assign w_wait_end   = (r_state == S_WAIT) && (w_done || (r_cnt == WAIT_LAST));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (cmd_valid)    w_state_nxt = S_DRIVE;
      S_DRIVE: if (w_settle_end) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_wait_end)   w_state_nxt = S_RESP;
      S_RESP:  if (rsp_ready)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 8'd0;
      r_a       <= 8'd0;
      r_b       <= 8'd0;
      r_uo      <= 8'd0;
      r_uio     <= 8'd0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            r_cnt <= 8'd0;
          end
        end
        S_DRIVE: begin
          r_cnt <= w_settle_end ? 8'd0 : r_cnt + 8'd1;
        end
        S_WAIT: begin
          if (w_wait_end) begin
            r_uo      <= dut_uo_out;
            r_uio     <= dut_uio_out & dut_uio_oe;
            r_timeout <= ~w_done;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_uo      <= 8'd0;
            r_uio     <= 8'd0;
            r_timeout <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // cmd_ready is masked by rst so nothing looks acceptable while reset is held
  always_comb begin
    cmd_ready   = 1'b0;
    busy        = 1'b1;
    rsp_valid   = 1'b0;
    rsp_uo      = 8'd0;
    rsp_uio     = 8'd0;
    rsp_timeout = 1'b0;
    dut_ena     = 1'b0;
    dut_ui_in   = 8'd0;
    dut_uio_in  = 8'd0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = ~rst;
        busy      = 1'b0;
      end
      S_DRIVE, S_WAIT: begin
        dut_ena    = 1'b1;
        dut_ui_in  = r_a;
        dut_uio_in = r_b & ~dut_uio_oe;
      end
      S_RESP: begin
        rsp_valid   = 1'b1;
        rsp_uo      = r_uo;
        rsp_uio     = r_uio;
        rsp_timeout = r_timeout;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/chip_host_driver.md
CHIP_HOST_DRIVER -- requirements
Module: chip_host_driver

Interface
REQ-001 Parameter SETTLE, default 1: cycles operands are driven before done-polling starts (1..15).
REQ-002 Parameter WAIT_MAX, default 16: max poll cycles before timeout (1..255).
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cmd_valid  in  1  command request.
REQ-006 cmd_ready  out  1  high only in IDLE.
REQ-007 cmd_a  in  8  operand for chip ui_in.
REQ-008 cmd_b  in  8  operand for chip uio_in.
REQ-009 rsp_valid  out  1  response available.
REQ-010 rsp_ready  in  1  response consumer ready.
REQ-011 rsp_uo  out  8  captured chip uo_out.
REQ-012 rsp_uio  out  8  captured chip uio_out masked by uio_oe.
REQ-013 rsp_timeout  out  1  response ended by timeout, not done.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 dut_ena  out  1  chip enable.
REQ-016 dut_ui_in  out  8  to chip ui_in.
REQ-017 dut_uio_in  out  8  to chip uio_in.
REQ-018 dut_uo_out  in  8  from chip uo_out.
REQ-019 dut_uio_out  in  8  from chip uio_out.
REQ-020 dut_uio_oe  in  8  from chip uio_oe (1 = chip drives bit).

Function
REQ-021 States SHALL be IDLE, DRIVE, WAIT, RESP; no other states reachable.
REQ-022 IDLE: cmd_ready=1; cmd_valid&cmd_ready latches cmd_a/cmd_b, clears counter, -> DRIVE.
REQ-023 DRIVE: lasts exactly SETTLE cycles, then -> WAIT with counter cleared.
REQ-024 dut_ena=1 and dut_ui_in=latched a in DRIVE and WAIT; both 0 in IDLE and RESP.
REQ-025 dut_uio_in SHALL equal latched b & ~dut_uio_oe in DRIVE/WAIT (never drive chip-owned bits), 0 otherwise.
REQ-026 done = dut_uio_oe[7] & dut_uio_out[7], sampled each WAIT cycle.
REQ-027 WAIT with done: capture rsp_uo=dut_uo_out, rsp_uio=dut_uio_out & dut_uio_oe, rsp_timeout=0, -> RESP.
REQ-028 WAIT without done at counter==WAIT_MAX-1: capture same fields, rsp_timeout=1, -> RESP; else counter+1.
REQ-029 done SHALL take priority over timeout in the final WAIT cycle.
REQ-030 RESP: rsp_valid=1, rsp_* stable until rsp_valid&rsp_ready, then -> IDLE.
REQ-031 cmd_valid outside IDLE SHALL be ignored; next command accepted no earlier than cycle after RESP handshake.
REQ-032 Latency: acceptance at cycle 0, done seen on k-th WAIT cycle (k>=1) -> rsp_valid first high at cycle SETTLE+k+1.
REQ-033 rsp_uo, rsp_uio, rsp_timeout SHALL read 0 whenever rsp_valid=0.

Reset
REQ-034 rst high at a clock edge SHALL force IDLE, counter 0, latched operands 0, captured fields 0.
REQ-035 Outputs while rst high after first edge: cmd_ready=0, busy=0, rsp_valid=0, all dut_* outputs 0.
REQ-036 First cycle after rst released: cmd_ready=1.
REQ-037 rst mid-transaction SHALL abandon it with no response issued.

Verification
REQ-038 rst high 3 cycles -> all outputs 0; cycle after release cmd_ready=1, busy=0.
REQ-039 SETTLE=1, a=0x3C b=0xA5, chip oe=0x8F, uio_out=0x85, uo_out=0x5A, done on 3rd WAIT cycle -> dut_uio_in=0x20 in WAIT, rsp_valid at cycle 5, rsp_uo=0x5A, rsp_uio=0x85, rsp_timeout=0.
REQ-040 WAIT_MAX=16, done never asserted -> rsp_valid at cycle 18, rsp_timeout=1, rsp_uo=current dut_uo_out.
REQ-041 done first asserted on 16th WAIT cycle -> rsp_timeout=0, rsp_valid at cycle 18.
REQ-042 rsp_ready low 5 cycles in RESP, cmd_valid high throughout -> rsp_* stable, cmd_ready=0; rsp_ready high -> IDLE next cycle, new command accepted then.
REQ-043 rst pulsed in 2nd WAIT cycle -> no rsp_valid, dut_ena=0 next cycle, cmd_ready=1 after release.
